bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter BIN_W, default 8: binary input width, legal range 4..32.
REQ-002 Parameter DIGITS, default 3: number of BCD output digits, legal range 1..10.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port start, input, 1: conversion request, sampled only in IDLE.
REQ-006 Port binary, input, BIN_W: value to convert, captured on the edge that accepts start.
REQ-007 Port busy, output, 1: high from the cycle after start is accepted until the cycle done is high, inclusive.
REQ-008 Port done, output, 1: single-cycle pulse marking a valid result.
REQ-009 Port bcd, output, 4*DIGITS: packed result with digit 0 in bits [3:0]; holds its value between conversions.
REQ-010 Port overflow, output, 1: result exceeded 10^DIGITS-1; valid with done and held with bcd.
REQ-011 Port neg, output, 1: sign of the result; held with bcd.

Function
REQ-012 The FSM SHALL use four states: IDLE, ADJUST, SHIFT and DONE.
REQ-013 IDLE with start=1 SHALL transition to ADJUST and capture binary (or its magnitude, REQ-024) into a BIN_W shift register; the working BCD register SHALL clear and the iteration counter SHALL zero.
REQ-014 ADJUST SHALL, in one cycle, add 3 to every working digit whose value is >=5 (all digits in parallel), then go to SHIFT.
REQ-015 SHIFT SHALL left-shift {working BCD, shift register} by one bit and increment the counter.
REQ-016 SHIFT SHALL go to DONE after the BIN_W-th shift and to ADJUST otherwise.
REQ-017 Any 1 shifted out of the top working digit SHALL set a sticky overflow bit for the current conversion.
REQ-018 DONE SHALL load bcd, overflow and neg from working state, pulse done=1, and return to IDLE.
REQ-019 Latency SHALL be fixed: done is high in the cycle after the (2*BIN_W+1)-th rising edge following the accepting edge (17 cycles for BIN_W=8), independent of value.
REQ-020 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-021 start held high continuously SHALL begin a new conversion in the cycle after done (back-to-back; one IDLE cycle).
REQ-022 On overflow, bcd SHALL carry the low DIGITS decimal digits of the value modulo 10^DIGITS.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, abort any conversion, and clear busy, done, overflow, neg, bcd and all working registers to 0; the first start is accepted on the first edge after rst_n rises.

Configuration
REQ-024 With macro BIN2BCD_SIGNED_EN defined, binary SHALL be treated as two's complement: neg SHALL be the captured MSB and the converted magnitude SHALL be |binary|; -2^(BIN_W-1) SHALL convert to magnitude 2^(BIN_W-1) correctly.
REQ-025 Without BIN2BCD_SIGNED_EN, binary SHALL be unsigned, neg SHALL be constant 0, and no negation logic SHALL be present.

Verification
REQ-026 Default parameters, binary=8'd255, start one cycle -> done pulse 17 cycles later, bcd=12'h255, overflow=0, busy high for 17 cycles.
REQ-027 binary=0, then binary=8'd99 back-to-back with start held high -> bcd=12'h000 then 12'h099, done pulses 18 cycles apart.
REQ-028 DIGITS=2, binary=8'd100 -> bcd=8'h00, overflow=1; then binary=8'd42 -> bcd=8'h42, overflow=0.
REQ-029 start pulsed again 5 cycles into a conversion with a different binary -> ignored; first result is delivered unchanged and exactly one done pulse occurs.
REQ-030 rst_n low for one cycle mid-conversion -> bcd=0, busy=0, no done pulse; the next start converts normally.
REQ-031 BIN2BCD_SIGNED_EN defined: binary=8'h80 -> neg=1, bcd=12'h128; binary=8'hFF -> neg=1, bcd=12'h001; binary=8'h7F -> neg=0, bcd=12'h127.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: multi-cycle double-dabble binary to packed-BCD converter.
// Define BIN2BCD_SIGNED_EN to treat binary as two's complement.
module bin2bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [BIN_W-1:0]    binary,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] bcd,
   output logic                overflow,
   output logic                neg
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(BIN_W + 1);
   localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

   typedef enum logic [1:0] {IDLE, ADJUST, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [BIN_W-1:0] sr_q, sr_d;
   logic [BW-1:0]    work_q, work_d;
   logic [BW-1:0]    bcd_q, bcd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sticky_q, sticky_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;
   logic [BW-1:0]    adj;
   logic [BW-1:0]    shifted;
   logic [BIN_W-1:0] mag;

`ifdef BIN2BCD_SIGNED_EN
   logic sign_q, sign_d;
   logic neg_q, neg_d;

   // -2^(BIN_W-1) negates to itself, which reads back correctly as unsigned
   always_comb mag = binary[BIN_W-1] ? (BIN_W'(0) - binary) : binary;
   assign neg = neg_q;
`else
   always_comb mag = binary;
   assign neg = 1'b0;
`endif

   always_comb begin
      adj = work_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (work_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
         end
      end
   end

   assign shifted = {work_q[BW-2:0], sr_q[BIN_W-1]};

   always_comb begin
      state_d  = state_q;
      sr_d     = sr_q;
      work_d   = work_q;
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      bcd_d    = bcd_q;
      ovf_d    = ovf_q;
`ifdef BIN2BCD_SIGNED_EN
      sign_d   = sign_q;
      neg_d    = neg_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = ADJUST;
               sr_d     = mag;
               work_d   = '0;
               cnt_d    = '0;
               sticky_d = 1'b0;
               busy_d   = 1'b1;
`ifdef BIN2BCD_SIGNED_EN
               sign_d   = binary[BIN_W-1];
`endif
            end
         end
         ADJUST: begin
            work_d  = adj;
            state_d = SHIFT;
         end
         SHIFT: begin
            work_d   = shifted;
            sr_d     = sr_q << 1;
            sticky_d = sticky_q | work_q[BW-1];
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // results register on entry so they are valid while in DONE
               state_d = DONE;
               bcd_d   = shifted;
               ovf_d   = sticky_q | work_q[BW-1];
               done_d  = 1'b1;
`ifdef BIN2BCD_SIGNED_EN
               neg_d   = sign_q;
`endif
            end else begin
               state_d = ADJUST;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sr_q     <= '0;
         work_q   <= '0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         bcd_q    <= '0;
         ovf_q    <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
         sign_q   <= 1'b0;
         neg_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         work_q   <= work_d;
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         bcd_q    <= bcd_d;
         ovf_q    <= ovf_d;
`ifdef BIN2BCD_SIGNED_EN
         sign_q   <= sign_d;
         neg_q    <= neg_d;
`endif
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign bcd      = bcd_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and random checks of bin2bcd_seq
// against an arithmetic decimal model, for DIGITS=3 and DIGITS=2.
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic [7:0]  binary_a = '0, binary_b = '0;
   logic        busy_a, done_a, ovf_a, neg_a;
   logic        busy_b, done_b, ovf_b, neg_b;
   logic [11:0] bcd_a;
   logic [7:0]  bcd_b;
   logic        sel = 1'b0;
   logic        busy_s, done_s, ovf_s, neg_s;
   logic [11:0] bcd_s;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .binary(binary_a),
      .busy(busy_a), .done(done_a), .bcd(bcd_a),
      .overflow(ovf_a), .neg(neg_a));

   bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .binary(binary_b),
      .busy(busy_b), .done(done_b), .bcd(bcd_b),
      .overflow(ovf_b), .neg(neg_b));

   assign busy_s = sel ? busy_b : busy_a;
   assign done_s = sel ? done_b : done_a;
   assign ovf_s  = sel ? ovf_b : ovf_a;
   assign neg_s  = sel ? neg_b : neg_a;
   assign bcd_s  = sel ? {4'h0, bcd_b} : bcd_a;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   function automatic void model(input bit s, input logic [7:0] v,
                                 output logic [11:0] b,
                                 output logic o, output logic n);
      int mag;
      int digits;
      digits = s ? 2 : 3;
      mag = int'(v);
      n = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      if (v[7]) begin
         mag = 256 - int'(v);
         n = 1'b1;
      end
`endif
      o = (mag >= (s ? 100 : 1000));
      b = '0;
      for (int i = 0; i < digits; i++) begin
         b[4*i +: 4] = 4'(mag % 10);
         mag = mag / 10;
      end
   endfunction

   task automatic conv(input bit s, input logic [7:0] v,
                       input logic [11:0] eb, input logic eo,
                       input logic en);
      int  cs;
      int  bn;
      bit  seen;
      sel = s;
      @(negedge clk);
      if (s) begin
         start_b = 1'b1;
         binary_b = v;
      end else begin
         start_a = 1'b1;
         binary_a = v;
      end
      cs = cyc;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      bn = 0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (busy_s) bn++;
         if (done_s) seen = 1'b1;
         else @(negedge clk);
      end
      chk("done_seen", 32'(seen), 32'd1);
      chk("latency", cyc - cs, 32'd17);
      chk("busy_cycles", bn, 32'd17);
      chk("bcd", 32'(bcd_s), 32'(eb));
      chk("overflow", 32'(ovf_s), 32'(eo));
      chk("neg", 32'(neg_s), 32'(en));
      @(negedge clk);
      chk("done_single", 32'(done_s), 32'd0);
      chk("bcd_hold", 32'(bcd_s), 32'(eb));
   endtask

   initial begin
      logic [11:0] eb, b1, b2;
      logic        eo, en;
      logic [7:0]  v;
      int          cs, d1, d2, nd;
      bit          seen;

      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_bcd", 32'(bcd_a), 32'd0);
      chk("rst_ovf", 32'(ovf_a), 32'd0);
      chk("rst_neg", 32'(neg_a), 32'd0);
      rst_n = 1'b1;

`ifdef BIN2BCD_SIGNED_EN
      conv(1'b0, 8'd255, 12'h001, 1'b0, 1'b1);
      conv(1'b0, 8'h80, 12'h128, 1'b0, 1'b1);
      conv(1'b0, 8'h7F, 12'h127, 1'b0, 1'b0);
      conv(1'b1, 8'd255, 12'h001, 1'b0, 1'b1);
`else
      conv(1'b0, 8'd255, 12'h255, 1'b0, 1'b0);
      conv(1'b0, 8'h80, 12'h128, 1'b0, 1'b0);
      conv(1'b0, 8'h7F, 12'h127, 1'b0, 1'b0);
      conv(1'b1, 8'd255, 12'h055, 1'b1, 1'b0);
`endif
      conv(1'b0, 8'd0, 12'h000, 1'b0, 1'b0);
      conv(1'b1, 8'd100, 12'h000, 1'b1, 1'b0);
      conv(1'b1, 8'd42, 12'h042, 1'b0, 1'b0);
      conv(1'b1, 8'd99, 12'h099, 1'b0, 1'b0);

      // back-to-back with start held high
      sel = 1'b0;
      @(negedge clk);
      start_a = 1'b1;
      binary_a = 8'd0;
      @(negedge clk);
      binary_a = 8'd99;
      seen = 1'b0;
      d1 = 0;
      b1 = '0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (done_a) begin
            seen = 1'b1;
            d1 = cyc;
            b1 = bcd_a;
         end else @(negedge clk);
      end
      @(negedge clk);
      seen = 1'b0;
      d2 = 0;
      b2 = '0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (done_a) begin
            seen = 1'b1;
            d2 = cyc;
            b2 = bcd_a;
            start_a = 1'b0;
         end else @(negedge clk);
      end
      start_a = 1'b0;
      chk("b2b_first", 32'(b1), 32'h000);
      chk("b2b_second", 32'(b2), 32'h099);
      chk("b2b_spacing", d2 - d1, 32'd18);
      repeat (3) @(negedge clk);

      // second start mid-conversion is dropped
      start_a = 1'b1;
      binary_a = 8'd123;
      @(negedge clk);
      start_a = 1'b0;
      repeat (4) @(negedge clk);
      start_a = 1'b1;
      binary_a = 8'd7;
      @(negedge clk);
      start_a = 1'b0;
      nd = 0;
      b1 = '0;
      for (int i = 0; i < 40; i++) begin
         if (done_a) begin
            nd++;
            b1 = bcd_a;
         end
         @(negedge clk);
      end
      chk("ignore_dones", nd, 32'd1);
      chk("ignore_bcd", 32'(b1), 32'h123);

      // reset mid-conversion
      start_a = 1'b1;
      binary_a = 8'd77;
      @(negedge clk);
      start_a = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst_busy", 32'(busy_a), 32'd0);
      chk("mrst_bcd", 32'(bcd_a), 32'd0);
      chk("mrst_done", 32'(done_a), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 25; i++) begin
         if (done_a) nd++;
         @(negedge clk);
      end
      chk("mrst_no_done", nd, 32'd0);
      conv(1'b0, 8'd45, 12'h045, 1'b0, 1'b0);

      for (int k = 0; k < 16; k++) begin
         v = 8'($urandom_range(0, 255));
         model(1'b0, v, eb, eo, en);
         conv(1'b0, v, eb, eo, en);
      end
      for (int k = 0; k < 8; k++) begin
         v = 8'($urandom_range(0, 255));
         model(1'b1, v, eb, eo, en);
         conv(1'b1, v, eb, eo, en);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
